// File: rtl/gray_to_bcd_seq.sv
// Bit-serial Gray-to-BCD decoder with valid/ready on both sides; all digits decode in parallel.
// Optional per-digit >9 flag when GRAY_BCD_RANGE_CHECK_EN is defined.

module gray_digit_step (
  input  logic [1:0] cnt,
  input  logic [3:0] g,
  input  logic [3:0] d,
  output logic [3:0] d_nxt
);
  // One decode step: bit cnt of the digit, MSB first
  always_comb begin
    d_nxt = d;
    case (cnt)
      2'd3:    d_nxt[3] = g[3];
      2'd2:    d_nxt[2] = d[3] ^ g[2];
      2'd1:    d_nxt[1] = d[2] ^ g[1];
      default: d_nxt[0] = d[1] ^ g[0];
    endcase
  end
endmodule

module gray_to_bcd_seq #(
  parameter  int NDIGITS = 2,
  localparam int W       = 4*NDIGITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_gray,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_bcd,
  output logic [NDIGITS-1:0] out_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     cnt;
  logic [W-1:0]   cap, dec, dec_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  for (genvar k = 0; k < NDIGITS; k++) begin : g_dig
    gray_digit_step u_step (
      .cnt  (cnt),
      .g    (cap[4*k +: 4]),
      .d    (dec[4*k +: 4]),
      .d_nxt(dec_nxt[4*k +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap     <= '0;
      dec     <= '0;
      cnt     <= 2'd3;
      out_bcd <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cap <= in_gray;
          cnt <= 2'd3;
        end
        SHIFT: begin
          dec <= dec_nxt;
          cnt <= cnt - 2'd1;
          // Final step: dec_nxt already holds the complete word
          if (cnt == '0) out_bcd <= dec_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef GRAY_BCD_RANGE_CHECK_EN
  logic [NDIGITS-1:0] err_nxt;
  for (genvar k = 0; k < NDIGITS; k++) begin : g_err
    assign err_nxt[k] = dec_nxt[4*k+3] & (dec_nxt[4*k+2] | dec_nxt[4*k+1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          out_err <= '0;
    else if (state == SHIFT && cnt == '0) out_err <= err_nxt;
  end
`else
  assign out_err = '0;
`endif

endmodule

// File: tb/tb_gray_to_bcd_seq.sv
// Directed bench for gray_to_bcd_seq (NDIGITS=2): reset, sweep, stall, range flag,
// back-to-back throughput and reset mid-decode.
module tb_gray_to_bcd_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_gray, out_bcd;
  logic [1:0] out_err;
  int checks = 0;
  int errors = 0;

`ifdef GRAY_BCD_RANGE_CHECK_EN
  localparam logic [1:0] F0_ERR = 2'b10;
`else
  localparam logic [1:0] F0_ERR = 2'b00;
`endif

  gray_to_bcd_seq #(.NDIGITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture one word, check 4-edge latency and result, then accept it.
  task automatic run_word(input string tag, input logic [7:0] g,
                          input logic [7:0] eb, input logic [1:0] ee);
    int n;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_gray = g; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_gray = ~g;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_bcd"}, 32'(out_bcd), 32'(eb));
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_hold"}, 32'(out_bcd), 32'(eb));
  endtask

  initial begin
    logic [3:0] gray_tab [10];
    logic [7:0] outs [2];
    int caps [2];
    int nc, no;
    logic hs_in, hs_out;
    logic [7:0] pre_bcd;

    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_gray = 8'h00;

    // Reset state
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd",   32'(out_bcd),   32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Sweep of the ten BCD Gray codes in both digits
    for (int i = 0; i < 10; i++)
      run_word($sformatf("sweep%0d", i), {gray_tab[i], gray_tab[i]},
               {4'(i), 4'(i)}, 2'b00);

    // Stall: output held for 10 cycles while upstream pushes another word
    run_word("w1d_pre", 8'h1D, 8'h19, 2'b00);
    in_gray = 8'h1D; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_gray = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_bcd", i),   32'(out_bcd),   32'h19);
      chk($sformatf("stall%0d_ready", i), 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("stall_release", 32'(out_valid), 32'd0);

    // Range flag
    run_word("f0", 8'hF0, 8'hA0, F0_ERR);

    // Back-to-back with in_valid and out_ready held high
    in_gray = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    nc = 0; no = 0; caps = '{-1, -1}; outs = '{8'hxx, 8'hxx};
    for (int cyc = 0; cyc < 30 && no < 2; cyc++) begin
      hs_in = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      pre_bcd = out_bcd;
      @(posedge clk); #1;
      if (hs_in && nc < 2) begin
        caps[nc] = cyc; nc++;
        if (nc == 1) in_gray = 8'h13;
        else in_valid = 1'b0;
      end
      if (hs_out) begin outs[no] = pre_bcd; no++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_out0", 32'(outs[0]), 32'h01);
    chk("b2b_out1", 32'(outs[1]), 32'h12);
    chk("b2b_spacing", 32'(caps[1] - caps[0]), 32'd6);

    // Reset during the second SHIFT cycle
    in_gray = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_bcd",   32'(out_bcd),   32'd0);
    chk("midrst_out_err",   32'(out_err),   32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst_quiet%0d", i), 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    run_word("post_rst", 8'h0C, 8'h08, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
